reaction_timer_ctrl: RTL

//  Sequencer for the starting-line game: arms a random delay from the PRBS, lights the LEDs,

---
 rtl/reaction_timer_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/reaction_timer_ctrl.sv
// Reaction timer sequencer for the starting-line game.
// Arms a PRBS-based delay, measures reaction in ms, flags false starts, tracks best time.
module reaction_timer_ctrl #(
    parameter int DELAY_W      = 7,
    parameter int MIN_DELAY_MS = 1000,
    parameter int DELAY_STEP   = 10,
    parameter int MAX_MS       = 9999,
    parameter int FLASH_MS     = 250,
    parameter int LED_W        = 10,
    localparam int RT_W        = $clog2(MAX_MS + 1)
) (
    input  logic               i_clk,
    input  logic               i_arst,
    input  logic               i_tickMs,
    input  logic               i_button,
    input  logic [DELAY_W-1:0] i_randomDelay,
    output logic               o_enPRBS,
    output logic [LED_W-1:0]   o_led,
    output logic [RT_W-1:0]    o_reactionMs,
    output logic [RT_W-1:0]    o_bestMs,
    output logic               o_falseStart,
    output logic               o_valid
);

    localparam int DLY_MAX = MIN_DELAY_MS + ((2 ** DELAY_W) - 1) * DELAY_STEP;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int FL_W    = $clog2(FLASH_MS + 1);

    localparam logic [DLY_W-1:0] DLY_MIN  = DLY_W'(MIN_DELAY_MS);
    localparam logic [DLY_W-1:0] DLY_STEP = DLY_W'(DELAY_STEP);
    localparam logic [RT_W-1:0]  RT_MAX   = RT_W'(MAX_MS);
    localparam logic [RT_W-1:0]  RT_LAST  = RT_W'(MAX_MS - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLASH_MS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_GO,
        S_FALSE,
        S_RESULT
    } state_t;

    state_t            state;
    state_t            nxt;
    logic              btn_q;
    logic              press;
    logic [DLY_W-1:0]  dly;
    logic [DLY_W-1:0]  dly_load;
    logic [RT_W-1:0]   rt;
    logic              rt_limit;
    logic [FL_W-1:0]   fcnt;
    logic              flash_on;

    assign press    = i_button & ~btn_q;
    assign rt_limit = (rt == RT_LAST);
    assign dly_load = DLY_MIN + DLY_W'(i_randomDelay) * DLY_STEP;

    // Registered button copy for rising-edge detection; held key at reset is not an edge
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= i_button;
        end
    end

    // State register
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state logic; a press always takes priority over tick-driven moves
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: begin
                if (press) nxt = S_WAIT;
            end
            S_WAIT: begin
                if (press) begin
                    nxt = S_FALSE;
                end else if (dly == '0) begin
                    nxt = S_GO;
                end else if (i_tickMs && dly == DLY_W'(1)) begin
                    nxt = S_GO;
                end
            end
            S_GO: begin
                if (press) begin
                    nxt = S_RESULT;
                end else if (i_tickMs && rt_limit) begin
                    nxt = S_RESULT;
                end
            end
            S_FALSE: begin
                if (press) nxt = S_IDLE;
            end
            S_RESULT: begin
                if (press) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs: LED pattern, PRBS enable, false-start flag
    always_comb begin
        o_led        = '0;
        o_enPRBS     = 1'b0;
        o_falseStart = 1'b0;
        case (state)
            S_IDLE: begin
                o_led    = LED_W'(1);
                o_enPRBS = 1'b1;
            end
            S_GO: begin
                o_led = '1;
            end
            S_FALSE: begin
                o_falseStart = 1'b1;
                o_led        = flash_on ? '1 : '0;
            end
            default: begin
                o_led = '0;
            end
        endcase
    end

    // Start delay: loaded on arm, counts down one per ms while waiting
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            dly <= '0;
        end else if (state == S_IDLE && press) begin
            dly <= dly_load;
        end else if (state == S_WAIT && !press && i_tickMs && dly != '0) begin
            dly <= dly - DLY_W'(1);
        end
    end

    // Reaction counter: cleared on GO entry, counts ms until press or saturation
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rt <= '0;
        end else if (state == S_WAIT && nxt == S_GO) begin
            rt <= '0;
        end else if (state == S_GO && !press && i_tickMs && !rt_limit) begin
            rt <= rt + RT_W'(1);
        end
    end

    // Result capture, best-time tracking and one-cycle valid pulse on RESULT entry
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_reactionMs <= '0;
            o_bestMs     <= RT_MAX;
            o_valid      <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (state == S_GO && press) begin
                o_reactionMs <= rt;
                o_valid      <= 1'b1;
                if (rt < o_bestMs) begin
                    o_bestMs <= rt;
                end
            end else if (state == S_GO && i_tickMs && rt_limit) begin
                o_reactionMs <= RT_MAX;
                o_valid      <= 1'b1;
            end
        end
    end

    // False-start flasher: starts lit, toggles every FLASH_MS ms
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            fcnt     <= '0;
            flash_on <= 1'b1;
        end else if (state != S_FALSE && nxt == S_FALSE) begin
            fcnt     <= '0;
            flash_on <= 1'b1;
        end else if (state == S_FALSE && i_tickMs) begin
            if (fcnt == FL_LAST) begin
                fcnt     <= '0;
                flash_on <= ~flash_on;
            end else begin
                fcnt <= fcnt + FL_W'(1);
            end
        end
    end

endmodule
